debug_run_controller: RTL and testbench
=======================================

// Module: debug_run_controller
// PURPOSE
// - Sequences the instruction phase decoder for debug: drives its DEBUG_STOPX to run, halt or single-step the CPU.
// - Takes run/halt/step commands from the debug port and optionally halts on PC breakpoints.
// - Counts retired instructions.
// - Sits between the debug interface and the phase decoder; observes the FETCH, COMMIT and STOPPED phase flags.
// PARAMETERS
// - NUM_BP      4   breakpoint comparators (1..8)
// - COUNT_W     16  width of retired-instruction counter
// - RESET_HALT  1   1: leave reset in HALTED; 0: leave reset in RUNNING
// PORTS
// - CLK          in   1        system clock
// - RESET        in   1        synchronous, active-high reset
// - CMD_VALID    in   1        command strobe
// - CMD          in   2        00 NOP, 01 HALT, 10 RUN, 11 STEP
// - CMD_READY    out  1        command accepted when CMD_VALID&CMD_READY
// - PC           in   16       address of instruction being fetched
// - FETCH        in   1        phase flag from decoder
// - COMMIT       in   1        phase flag from decoder
// - STOPPED      in   1        phase flag from decoder
// - DEBUG_STOPX  out  1        stop request to decoder
// - HALTED       out  1        controller in HALTED state
// - STEP_DONE    out  1        1-cycle pulse when a STEP reaches HALTED
// - BREAK_HIT    out  1        halt was caused by a breakpoint
// - INSTR_COUNT  out  COUNT_W  retired instructions since last RUN or STEP accept
// - BP_WE        in   1        breakpoint table write strobe
// - BP_SEL       in   3        entry index; entries >= NUM_BP are ignored
// - BP_ADDR      in   16       breakpoint address
// - BP_ENA       in   1        breakpoint entry enable
// BEHAVIOUR
// - Clock and reset: one clock, CLK. RESET is synchronous and active-high; all state is updated only on rising CLK.
// - Edge detect: FETCH and COMMIT are levels held across stalls. Use registered rising-edge detects: FETCH_E, COMMIT_E.
// - Reset values: DEBUG_STOPX=RESET_HALT; HALTED=0 until STOPPED is seen; STEP_DONE=0; BREAK_HIT=0; INSTR_COUNT=0; all BP entries disabled.
//   - RESET_HALT=1: state=HALTING.
//   - RESET_HALT=0: state=RUNNING.
// - States and transitions:
//   - RUNNING: DEBUG_STOPX=0, CMD_READY=1.
//     - HALT -> HALTING.
//     - Breakpoint match -> HALTING, BREAK_HIT<=1.
//     - RUN, STEP and NOP are no-ops.
//   - HALTING: DEBUG_STOPX=1, CMD_READY=0. STOPPED=1 -> HALTED (a step in progress also raises STEP_DONE for 1 cycle).
//   - HALTED: DEBUG_STOPX=1, HALTED=1, CMD_READY=1.
//     - RUN -> RUNNING.
//     - STEP -> STEP_LAUNCH.
//     - HALT and NOP are no-ops.
//     - Accepting RUN or STEP clears BREAK_HIT and INSTR_COUNT.
//   - STEP_LAUNCH: DEBUG_STOPX=0, CMD_READY=0. FETCH_E -> HALTING with step flag set. Stop is re-asserted before that instruction's COMMIT, so exactly one instruction retires.
// - Breakpoints: match = FETCH_E & any enabled entry with BP_ADDR==PC.
//   - Acts in RUNNING only; ignored in STEP_LAUNCH so stepping over a breakpoint works.
//   - The matching instruction completes; the halt takes effect after its COMMIT.
// - INSTR_COUNT: +1 per COMMIT_E; saturates at all-ones (no wrap).
// - Table writes: BP_WE writes entry BP_SEL every cycle in any state; new value is used from the next cycle. A write and a match in the same cycle use the old entry.
// - Command handshake: CMD_VALID with CMD_READY=0 is dropped, not queued. Latency from accept to DEBUG_STOPX change is 1 cycle.
// - RESET mid-operation: all state returns to the reset values on the next edge, regardless of the current phase.
// CONFIGURATION
// - DEBUG_BREAKPOINT_EN defined: breakpoint table and match logic are built as described above.
// - DEBUG_BREAKPOINT_EN undefined:
//   - No table is built; BP_* inputs are ignored.
//   - BREAK_HIT is tied to 0.
//   - Only commands cause halts.
// TESTING
// - Reset, RESET_HALT=1; decoder raises STOPPED at cycle 3
//   -> DEBUG_STOPX=1, CMD_READY=0 until then; HALTED=1, CMD_READY=1 from cycle 4; INSTR_COUNT=0.
// - HALTED; STEP accepted
//   -> DEBUG_STOPX low until FETCH_E, then high; one COMMIT_E; STEP_DONE pulses once; HALTED=1; INSTR_COUNT=1.
// - RUN; BP0=0x0040 enabled; fetch at PC=0x0040
//   -> that instruction commits; state goes to HALTED; BREAK_HIT=1; a following STEP retires 0x0040's successor and clears BREAK_HIT.
// - RUNNING; HALT issued; CMD_VALID=1 CMD=RUN on the next cycle (HALTING)
//   -> CMD_READY=0 and RUN is dropped; controller settles in HALTED.
// - STEP in progress; RESET for 1 cycle
//   -> all outputs return to reset values; no STEP_DONE pulse.
// - COUNT_W=4, 20 instructions retired while RUNNING -> INSTR_COUNT=4'hF (saturated).

Source files
------------

// File: rtl/debug_run_controller.sv
// Debug run/halt/step sequencer driving the phase decoder's DEBUG_STOPX.
// Ports: CLK/RESET, CMD_VALID/CMD/CMD_READY command handshake,
//   PC/FETCH/COMMIT/STOPPED from the decoder, DEBUG_STOPX to it,
//   HALTED/STEP_DONE/BREAK_HIT/INSTR_COUNT status, BP_* table writes.
// Build option: define DEBUG_BREAKPOINT_EN to build the PC breakpoint table.
module debug_run_controller #(
  parameter int NUM_BP     = 4,
  parameter int COUNT_W    = 16,
  parameter int RESET_HALT = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CMD_VALID,
  input  logic [1:0]         CMD,
  output logic               CMD_READY,
  input  logic [15:0]        PC,
  input  logic               FETCH,
  input  logic               COMMIT,
  input  logic               STOPPED,
  output logic               DEBUG_STOPX,
  output logic               HALTED,
  output logic               STEP_DONE,
  output logic               BREAK_HIT,
  output logic [COUNT_W-1:0] INSTR_COUNT,
  input  logic               BP_WE,
  input  logic [2:0]         BP_SEL,
  input  logic [15:0]        BP_ADDR,
  input  logic               BP_ENA
);

  localparam logic [1:0] CMD_HALT = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  typedef enum logic [1:0] {
    S_RUNNING,
    S_HALTING,
    S_HALTED,
    S_STEP_LAUNCH
  } state_t;

  localparam state_t RST_STATE =
    (RESET_HALT != 0) ? S_HALTING : S_RUNNING;

  state_t state, state_n;

  logic               fetch_q, commit_q;
  logic               fetch_e, commit_e;
  logic               step_flag;
  logic               step_done_q;
  logic               break_hit_q;
  logic [COUNT_W-1:0] count_q;
  logic               bp_match;

  logic stopx, ready, halted;
  logic clr, set_bh, set_step, step_done_n;

  // FETCH/COMMIT are levels held through stalls; act on the rising edge only.
  assign fetch_e  = FETCH & ~fetch_q;
  assign commit_e = COMMIT & ~commit_q;

`ifdef DEBUG_BREAKPOINT_EN
  logic [15:0] bp_addr_q [NUM_BP];
  logic        bp_ena_q  [NUM_BP];

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_BP; i++) begin
      if (RESET) begin
        bp_addr_q[i] <= '0;
        bp_ena_q[i]  <= 1'b0;
      end else if (BP_WE && BP_SEL == 3'(i)) begin
        bp_addr_q[i] <= BP_ADDR;
        bp_ena_q[i]  <= BP_ENA;
      end
    end
  end

  // Reads the registered table, so a same-cycle write sees the old entry.
  always_comb begin
    bp_match = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_ena_q[i] && bp_addr_q[i] == PC) bp_match = 1'b1;
    end
    bp_match = bp_match & fetch_e;
  end

  assign BREAK_HIT = break_hit_q;
`else
  logic unused_bp;
  assign unused_bp = ^{PC, BP_WE, BP_SEL, BP_ADDR, BP_ENA, break_hit_q};
  assign bp_match  = 1'b0;
  assign BREAK_HIT = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    stopx       = 1'b1;
    ready       = 1'b0;
    halted      = 1'b0;
    clr         = 1'b0;
    set_bh      = 1'b0;
    set_step    = 1'b0;
    step_done_n = 1'b0;
    unique case (state)
      S_RUNNING: begin
        stopx = 1'b0;
        ready = 1'b1;
        if (bp_match) begin
          state_n = S_HALTING;
          set_bh  = 1'b1;
        end else if (CMD_VALID && CMD == CMD_HALT) begin
          state_n = S_HALTING;
        end
      end
      S_HALTING: begin
        if (STOPPED) begin
          state_n     = S_HALTED;
          step_done_n = step_flag;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        ready  = 1'b1;
        if (CMD_VALID && CMD == CMD_RUN) begin
          state_n = S_RUNNING;
          clr     = 1'b1;
        end else if (CMD_VALID && CMD == CMD_STEP) begin
          state_n = S_STEP_LAUNCH;
          clr     = 1'b1;
        end
      end
      S_STEP_LAUNCH: begin
        // Re-stop on the fetch edge so only this instruction commits.
        stopx = 1'b0;
        if (fetch_e) begin
          state_n  = S_HALTING;
          set_step = 1'b1;
        end
      end
      default: state_n = RST_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RST_STATE;
      fetch_q     <= 1'b0;
      commit_q    <= 1'b0;
      step_flag   <= 1'b0;
      step_done_q <= 1'b0;
      break_hit_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state       <= state_n;
      fetch_q     <= FETCH;
      commit_q    <= COMMIT;
      step_done_q <= step_done_n;
      if (set_step)
        step_flag <= 1'b1;
      else if (state == S_HALTING && STOPPED)
        step_flag <= 1'b0;
      if (clr)
        break_hit_q <= 1'b0;
      else if (set_bh)
        break_hit_q <= 1'b1;
      if (clr)
        count_q <= '0;
      else if (commit_e && count_q != '1)
        count_q <= count_q + COUNT_W'(1);
    end
  end

  assign DEBUG_STOPX = stopx;
  assign CMD_READY   = ready;
  assign HALTED      = halted;
  assign STEP_DONE   = step_done_q;
  assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_debug_run_controller.sv
// Directed self-checking bench for debug_run_controller.
// Drives decoder phase flags by hand; checks outputs on the falling edge.
module tb_debug_run_controller;

  localparam logic [1:0] C_HALT = 2'b01;
  localparam logic [1:0] C_RUN  = 2'b10;
  localparam logic [1:0] C_STEP = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] pc = 16'h0;
  logic        fetch = 1'b0;
  logic        commit = 1'b0;
  logic        stopped = 1'b0;
  logic        bp_we = 1'b0;
  logic [2:0]  bp_sel = 3'd0;
  logic [15:0] bp_addr = 16'h0;
  logic        bp_ena = 1'b0;

  logic        cmd_ready, stopx, halted, step_done, break_hit;
  logic [15:0] count;
  logic        r_ready, r_stopx, r_halted, r_step_done, r_break_hit;
  logic [3:0]  r_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debug_run_controller #(
    .NUM_BP(4), .COUNT_W(16), .RESET_HALT(1)
  ) u_dut (
    .CLK(clk), .RESET(rst),
    .CMD_VALID(cmd_valid), .CMD(cmd), .CMD_READY(cmd_ready),
    .PC(pc), .FETCH(fetch), .COMMIT(commit), .STOPPED(stopped),
    .DEBUG_STOPX(stopx), .HALTED(halted), .STEP_DONE(step_done),
    .BREAK_HIT(break_hit), .INSTR_COUNT(count),
    .BP_WE(bp_we), .BP_SEL(bp_sel), .BP_ADDR(bp_addr), .BP_ENA(bp_ena)
  );

  debug_run_controller #(
    .NUM_BP(4), .COUNT_W(4), .RESET_HALT(0)
  ) u_run (
    .CLK(clk), .RESET(rst),
    .CMD_VALID(1'b0), .CMD(cmd), .CMD_READY(r_ready),
    .PC(pc), .FETCH(fetch), .COMMIT(commit), .STOPPED(stopped),
    .DEBUG_STOPX(r_stopx), .HALTED(r_halted), .STEP_DONE(r_step_done),
    .BREAK_HIT(r_break_hit), .INSTR_COUNT(r_count),
    .BP_WE(1'b0), .BP_SEL(bp_sel), .BP_ADDR(bp_addr), .BP_ENA(bp_ena)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    cyc();
    cmd_valid = 1'b0;
    cmd = 2'b00;
  endtask

  task automatic retire(input logic [15:0] a);
    pc = a;
    fetch = 1'b1;
    cyc();
    fetch = 1'b0;
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    cyc();
  endtask

  initial begin
    // Reset, then decoder reports STOPPED on the third cycle.
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("rst_stopx1", 32'(stopx), 1);
    chk("rst_ready1", 32'(cmd_ready), 0);
    chk("rst_halted1", 32'(halted), 0);
    chk("rst_bh", 32'(break_hit), 0);
    chk("rst_sd", 32'(step_done), 0);
    chk("run_rst_stopx", 32'(r_stopx), 0);
    chk("run_rst_ready", 32'(r_ready), 1);
    chk("run_rst_halted", 32'(r_halted), 0);
    cyc();
    chk("rst_stopx2", 32'(stopx), 1);
    chk("rst_ready2", 32'(cmd_ready), 0);
    stopped = 1'b1;
    cyc();
    chk("rst_halted", 32'(halted), 1);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_stopx", 32'(stopx), 1);
    chk("rst_count", 32'(count), 0);

    // Single step from HALTED.
    send(C_STEP);
    chk("step_launch_stopx", 32'(stopx), 0);
    chk("step_launch_ready", 32'(cmd_ready), 0);
    stopped = 1'b0;
    pc = 16'h0010;
    fetch = 1'b1;
    cyc();
    chk("step_restop", 32'(stopx), 1);
    chk("step_not_halted", 32'(halted), 0);
    fetch = 1'b0;
    commit = 1'b1;
    cyc();
    chk("step_count", 32'(count), 1);
    commit = 1'b0;
    stopped = 1'b1;
    cyc();
    chk("step_halted", 32'(halted), 1);
    chk("step_done", 32'(step_done), 1);
    cyc();
    chk("step_done_pulse", 32'(step_done), 0);
    chk("step_count2", 32'(count), 1);

    // Breakpoint table: entry 0 = 0x0040; entry 5 does not exist.
    bp_we = 1'b1;
    bp_sel = 3'd0;
    bp_addr = 16'h0040;
    bp_ena = 1'b1;
    cyc();
    bp_sel = 3'd5;
    bp_addr = 16'h003C;
    cyc();
    bp_we = 1'b0;

    send(C_RUN);
    stopped = 1'b0;
    chk("run_stopx", 32'(stopx), 0);
    chk("run_clr_count", 32'(count), 0);
    chk("run_halted", 32'(halted), 0);
    retire(16'h003C);
    chk("bp_oob_ignored", 32'(stopx), 0);
    chk("run_count1", 32'(count), 1);
`ifdef DEBUG_BREAKPOINT_EN
    pc = 16'h0040;
    fetch = 1'b1;
    cyc();
    chk("bp_stopx", 32'(stopx), 1);
    chk("bp_hit", 32'(break_hit), 1);
    fetch = 1'b0;
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    cyc();
    chk("bp_commits", 32'(count), 2);
    chk("bp_halting", 32'(halted), 0);
    stopped = 1'b1;
    cyc();
    chk("bp_halted", 32'(halted), 1);
    chk("bp_no_sd", 32'(step_done), 0);
    chk("bp_hit_hold", 32'(break_hit), 1);
    send(C_STEP);
    chk("bp_step_clr", 32'(break_hit), 0);
    chk("bp_step_cnt0", 32'(count), 0);
    stopped = 1'b0;
    pc = 16'h0042;
    fetch = 1'b1;
    cyc();
    chk("bp_step_restop", 32'(stopx), 1);
    fetch = 1'b0;
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    stopped = 1'b1;
    cyc();
    chk("bp_step_halted", 32'(halted), 1);
    chk("bp_step_done", 32'(step_done), 1);
    chk("bp_step_count", 32'(count), 1);
`else
    retire(16'h0040);
    chk("nobp_running", 32'(stopx), 0);
    chk("nobp_bh", 32'(break_hit), 0);
    chk("nobp_count", 32'(count), 2);
    send(C_HALT);
    stopped = 1'b1;
    cyc();
    chk("nobp_halted", 32'(halted), 1);
`endif

    // HALT, then RUN offered while HALTING is dropped.
    send(C_RUN);
    stopped = 1'b0;
    chk("hd_running", 32'(stopx), 0);
    cmd_valid = 1'b1;
    cmd = C_HALT;
    cyc();
    cmd = C_RUN;
    chk("hd_ready0", 32'(cmd_ready), 0);
    cyc();
    cmd_valid = 1'b0;
    chk("hd_stopx", 32'(stopx), 1);
    chk("hd_not_halted", 32'(halted), 0);
    stopped = 1'b1;
    cyc();
    chk("hd_halted", 32'(halted), 1);
    cyc();
    chk("hd_dropped_stopx", 32'(stopx), 1);
    chk("hd_dropped_halted", 32'(halted), 1);

    // 20 retires while RUNNING; 4-bit counter saturates.
    send(C_RUN);
    stopped = 1'b0;
    for (int i = 0; i < 20; i++) retire(16'h0100 + 16'(2 * i));
    chk("sat_count16", 32'(count), 20);
    chk("sat_count4", 32'(r_count), 32'hF);
    chk("sat_running", 32'(stopx), 0);

    // RESET in the middle of a step.
    send(C_HALT);
    stopped = 1'b1;
    cyc();
    chk("mid_halted", 32'(halted), 1);
    send(C_STEP);
    stopped = 1'b0;
    pc = 16'h0200;
    fetch = 1'b1;
    cyc();
    fetch = 1'b0;
    commit = 1'b1;
    cyc();
    commit = 1'b0;
    chk("mid_count", 32'(count), 1);
    chk("mid_stopx", 32'(stopx), 1);
    rst = 1'b1;
    stopped = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_stopx", 32'(stopx), 1);
    chk("mid_rst_halted", 32'(halted), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_sd", 32'(step_done), 0);
    chk("mid_rst_run_cnt", 32'(r_count), 0);
    cyc();
    chk("mid_settle_halted", 32'(halted), 1);
    chk("mid_no_step_done", 32'(step_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
